// File: rtl/i2s_tx_serializer_if.sv
// i2s_tx_serializer_if: sample-pair valid/ready handshake into the I2S transmitter.
interface i2s_tx_serializer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] sample_left;
    logic [DATA_W-1:0] sample_right;
    logic [1:0]        sample_size;
    logic              sample_valid;
    logic              sample_ready;
    modport master(output sample_left, sample_right, sample_size, sample_valid, input sample_ready);
    modport slave(input sample_left, sample_right, sample_size, sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: Philips I2S transmitter with one-entry holding register and underrun reporting.
module i2s_tx_serializer #(
    parameter int DATA_W     = 32,
    parameter int FRAME_SLOT = 32,
    parameter int CLK_DIV    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    i2s_tx_serializer_if.slave         s_if,
    input  logic                       enable_i,
    output logic                       sclk_o,
    output logic                       ws_o,
    output logic                       sd_o,
    output logic                       busy_o,
    output logic                       underrun_o
);
    localparam int PW   = $clog2(2 * FRAME_SLOT);
    localparam int DW   = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int MAXB = DATA_W < FRAME_SLOT ? DATA_W : FRAME_SLOT;
    localparam logic [PW-1:0] PLAST = PW'(2 * FRAME_SLOT - 1);
    localparam logic [DW-1:0] DLAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] hold_l_q, hold_r_q, left_q, right_q, ld_l, ld_r;
    logic [5:0]        hold_sz_q, size_q, ld_sz, req, size_in;
    logic [PW-1:0]     p_q, p_d;
    logic [DW-1:0]     div_q;
    logic              hold_full_q, hold_full_d, ready_q;
    logic              sclk_q, ws_q, sd_q, busy_q, underrun_q;
    logic              accept, fall, wrap, load, sd_d, ws_d;

    function automatic logic bit_at(input logic [PW-1:0] p, input logic [DATA_W-1:0] l,
                                    input logic [DATA_W-1:0] r, input logic [5:0] sz);
        int                o;
        logic [DATA_W-1:0] ch;
        o  = (p >= PW'(FRAME_SLOT)) ? int'(p) - FRAME_SLOT : int'(p);
        ch = (p >= PW'(FRAME_SLOT)) ? r : l;
        ch = ch >> (int'(sz) - 1 - o);
        return (o < int'(sz)) && ch[0];
    endfunction

    // Shift data seen by sd_d is the freshly loaded frame on a load cycle, else the current one.
    always_comb begin
        accept      = s_if.sample_valid && ready_q;
        fall        = state_q == RUN && sclk_q && div_q == DLAST;
        wrap        = fall && p_q == PLAST;
        load        = state_q == LOAD || (wrap && enable_i);
        hold_full_d = accept || (hold_full_q && !load);
        req         = {1'b0, s_if.sample_size, 3'b000} + 6'd8;
        size_in     = req > 6'(MAXB) ? 6'(MAXB) : req;
        ld_l        = !load ? left_q : hold_full_q ? hold_l_q : '0;
        ld_r        = !load ? right_q : hold_full_q ? hold_r_q : '0;
        ld_sz       = load && hold_full_q ? hold_sz_q : size_q;
        p_d         = (state_q == LOAD || wrap) ? '0 : p_q + 1'b1;
        sd_d        = bit_at(p_d, ld_l, ld_r, ld_sz);
        ws_d        = p_d >= PW'(FRAME_SLOT - 1) && p_d <= PW'(2 * FRAME_SLOT - 2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            hold_sz_q   <= '0;
            left_q      <= '0;
            right_q     <= '0;
            size_q      <= '0;
            p_q         <= '0;
            div_q       <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b0;
            sclk_q      <= 1'b0;
            ws_q        <= 1'b0;
            sd_q        <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            ready_q     <= !hold_full_d;
            underrun_q  <= load && !hold_full_q;
            if (accept) begin
                hold_l_q  <= s_if.sample_left;
                hold_r_q  <= s_if.sample_right;
                hold_sz_q <= size_in;
            end
            if (load) begin
                left_q  <= ld_l;
                right_q <= ld_r;
                size_q  <= ld_sz;
            end
            case (state_q)
                IDLE: begin
                    sclk_q <= 1'b0;
                    div_q  <= '0;
                    if (enable_i && hold_full_d) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    state_q <= RUN;
                    p_q     <= p_d;
                    sd_q    <= sd_d;
                    ws_q    <= ws_d;
                    div_q   <= '0;
                end
                RUN: begin
                    div_q <= div_q == DLAST ? '0 : div_q + 1'b1;
                    if (div_q == DLAST) sclk_q <= !sclk_q;
                    if (wrap && !enable_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        sclk_q  <= 1'b0;
                        ws_q    <= 1'b0;
                        sd_q    <= 1'b0;
                        p_q     <= '0;
                    end else if (fall) begin
                        p_q  <= p_d;
                        sd_q <= sd_d;
                        ws_q <= ws_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    sclk_q  <= 1'b0;
                    ws_q    <= 1'b0;
                    sd_q    <= 1'b0;
                end
            endcase
        end
    end

    assign s_if.sample_ready = ready_q;
    assign sclk_o            = sclk_q;
    assign ws_o              = ws_q;
    assign sd_o              = sd_q;
    assign busy_o            = busy_q;
    assign underrun_o        = underrun_q;
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer: scoreboard bench; 16-bit slots, 2 clk per SCLK half-period.
module tb_i2s_tx_serializer;
    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0;
    logic        sclk, ws, sd, busy, underrun;
    logic        sclk_prev = 1'b0, ur_prev = 1'b0;
    logic [31:0] sd_v = '0, ws_v = '0, q_exp;
    logic [31:0] exp_q[$];
    int          vecs = 0, errs = 0, ur_cnt = 0, k = 0;

    // {left, right, size code, expected frame: left slot bits 31..16, right slot bits 15..0}
    logic [97:0] vec_tab[4] = '{
        {32'h0000_A5A5, 32'h0000_3C3C, 2'd1, 32'hA5A5_3C3C},
        {32'h8000_0001, 32'h1234_5678, 2'd3, 32'h0001_5678},
        {32'h1234_56AB, 32'h0000_00CD, 2'd0, 32'hAB00_CD00},
        {32'h00FF_1357, 32'h0000_8001, 2'd2, 32'h1357_8001}
    };

    i2s_tx_serializer_if #(.DATA_W(32)) bus();

    i2s_tx_serializer #(.DATA_W(32), .FRAME_SLOT(16), .CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .s_if(bus), .enable_i(enable),
        .sclk_o(sclk), .ws_o(ws), .sd_o(sd), .busy_o(busy), .underrun_o(underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vecs++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Monitor: collect one bit per SCLK rise; a complete 32-bit frame is checked against the queue.
    always @(negedge clk) begin
        if (rst || !busy) k = 0;
        else if (sclk && !sclk_prev) begin
            sd_v[31-k] = sd;
            ws_v[31-k] = ws;
            k++;
            if (k == 32) begin
                k = 0;
                if (exp_q.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL frame_unexpected: got %h expected none", sd_v);
                end else begin
                    q_exp = exp_q.pop_front();
                    chk("frame_sd", sd_v, q_exp);
                    chk("frame_ws", ws_v, 32'h0001_FFFE);
                end
            end
        end
        if (underrun) begin
            ur_cnt++;
            chk("underrun_busy", 32'(busy), 32'd1);
            chk("underrun_width", 32'(ur_prev), 32'd0);
        end
        ur_prev   = underrun;
        sclk_prev = sclk;
    end

    task automatic send(input logic [31:0] l, input logic [31:0] r, input logic [1:0] c,
                        input logic [31:0] e, input bit push);
        int t = 0;
        bus.sample_left  = l;
        bus.sample_right = r;
        bus.sample_size  = c;
        bus.sample_valid = 1'b1;
        while (!bus.sample_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!bus.sample_ready) begin
            vecs++;
            errs++;
            $display("FAIL send_timeout: ready=%b after %0d cycles, expected 1", bus.sample_ready, t);
        end else begin
            @(posedge clk);
            if (push) exp_q.push_back(e);
        end
        @(negedge clk);
        bus.sample_valid = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int lim, input string nm);
        int t = 0;
        while (busy !== lvl && t < lim) begin
            @(negedge clk);
            t++;
        end
        chk(nm, 32'(busy), 32'(lvl));
    endtask

    initial begin
        int t;
        bus.sample_left  = '0;
        bus.sample_right = '0;
        bus.sample_size  = '0;
        bus.sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({sclk, ws, sd, busy, underrun, bus.sample_ready}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.sample_ready), 32'd1);
        chk("idle_outputs", 32'({sclk, ws, sd, busy}), 32'd0);
        enable = 1'b1;
        foreach (vec_tab[i]) send(vec_tab[i][97:66], vec_tab[i][65:34], vec_tab[i][33:32], vec_tab[i][31:0], 1'b1);
        for (int i = 0; i < 8; i++)
            send(32'h0000_1000 + 32'(i), 32'h0000_2000 + 32'(i), 2'd1, {16'h1000 + 16'(i), 16'h2000 + 16'(i)}, 1'b1);
        chk("no_underrun_b2b", 32'(ur_cnt), 32'd0);
        exp_q.push_back(32'h0);
        t = 0;
        while (ur_cnt == 0 && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk("underrun_seen", 32'(ur_cnt), 32'd1);
        repeat (40) @(negedge clk);
        enable = 1'b0;
        send(32'h0000_BEEF, 32'h0000_CAFE, 2'd1, 32'hBEEF_CAFE, 1'b1);
        wait_busy(1'b0, 400, "idle_after_disable");
        chk("idle_pins", 32'({sclk, ws, sd}), 32'd0);
        chk("hold_retained", 32'(bus.sample_ready), 32'd0);
        repeat (5) @(negedge clk);
        chk("idle_stays", 32'(busy), 32'd0);
        enable = 1'b1;
        wait_busy(1'b1, 10, "restart");
        repeat (20) @(negedge clk);
        enable = 1'b0;
        wait_busy(1'b0, 400, "idle_after_buffered");
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        enable = 1'b1;
        send(32'h0000_5555, 32'h0000_AAAA, 2'd1, 32'h0, 1'b0);
        wait_busy(1'b1, 10, "busy_before_reset");
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", 32'({sclk, ws, sd, busy, underrun, bus.sample_ready}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_midreset", 32'(bus.sample_ready), 32'd1);
        repeat (10) @(negedge clk);
        chk("hold_discarded", 32'(busy), 32'd0);
        chk("underrun_total", 32'(ur_cnt), 32'd1);
        chk("queue_final", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
